// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the pipelined MIPS32 core: opcodes, instruction
// classes, memory size and the memory responder's state/port types.
package pipe_mips32_pkg;

    localparam int MEM_DEPTH = 1024;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT
    } instr_type_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_sel_t;

endpackage

// File: rtl/pipe_mem_array.sv
// Single-port synchronous RAM: write-enable, registered read, contents not reset.
module pipe_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pipe_mem_responder.sv
// Two-requester memory responder (instruction read port, data read/write port)
// sharing one array, with alternating arbitration and fixed wait states.
module pipe_mem_responder
    import pipe_mips32_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    mem_state_t        state, state_nxt;
    port_sel_t         prio_port, grant_port, lat_port;
    logic              any_req, grant;
    logic [31:0]       grant_addr, lat_addr;
    logic              lat_we, lat_err;
    logic [DATA_W-1:0] lat_wdata, ram_rdata, resp_data;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic [CNT_W-1:0]  count;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;

    // On contention prio_port wins; it flips to the other port after every access.
    always_comb begin
        any_req    = i_req | d_req;
        grant_port = PORT_I;
        if (i_req && d_req) begin
            grant_port = prio_port;
        end else if (d_req) begin
            grant_port = PORT_D;
        end
        grant_addr = (grant_port == PORT_D) ? d_addr : i_addr;
        grant      = (state == IDLE) && any_req;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (count == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            lat_port  <= PORT_I;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            count     <= '0;
        end else if (grant) begin
            lat_port  <= grant_port;
            lat_addr  <= grant_addr;
            lat_we    <= (grant_port == PORT_D) && d_we;
            lat_wdata <= d_wdata;
            lat_err   <= (grant_addr >= 32'(DEPTH));
            count     <= CNT_W'(WAIT_STATES);
        end else if (state == WAIT) begin
            count <= count - CNT_W'(1);
        end
    end

    // Response data holds per port until that port's next ack.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            prio_port <= PORT_I;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (state == RESP) begin
            prio_port <= (lat_port == PORT_I) ? PORT_D : PORT_I;
            if (lat_port == PORT_I) begin
                i_rdata_q <= resp_data;
            end else begin
                d_rdata_q <= resp_data;
            end
        end
    end

    // The RAM read is issued one edge before RESP so its registered output lines up with the ack.
    always_comb begin
        ram_addr  = (state == IDLE) ? grant_addr[ADDR_W-1:0] : lat_addr[ADDR_W-1:0];
        ram_we    = (state == RESP) && lat_we && !lat_err;
        resp_data = (lat_err || lat_we) ? '0 : ram_rdata;
        i_ack     = (state == RESP) && (lat_port == PORT_I);
        d_ack     = (state == RESP) && (lat_port == PORT_D);
        i_err     = i_ack && lat_err;
        d_err     = d_ack && lat_err;
        i_rdata   = i_ack ? resp_data : i_rdata_q;
        d_rdata   = d_ack ? resp_data : d_rdata_q;
        busy      = (state != IDLE);
    end

    pipe_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk1  (clk1),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Self-checking bench for pipe_mem_responder: one instance with one wait state,
// one with none, checked every cycle against a transaction-level memory model.
`timescale 1ns/1ps
module tb_pipe_mem_responder;
    import pipe_mips32_pkg::*;

    localparam int NI    = 2;
    localparam int DEPTH = 1024;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        i_req   [NI];
    logic [31:0] i_addr  [NI];
    logic        i_ack   [NI];
    logic [31:0] i_rdata [NI];
    logic        i_err   [NI];
    logic        d_req   [NI];
    logic        d_we    [NI];
    logic [31:0] d_addr  [NI];
    logic [31:0] d_wdata [NI];
    logic        d_ack   [NI];
    logic [31:0] d_rdata [NI];
    logic        d_err   [NI];
    logic        busy    [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc++;

    pipe_mem_responder #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(1)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]), .i_err(i_err[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ack(d_ack[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]), .busy(busy[0])
    );

    pipe_mem_responder #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
        .clk1(clk1), .rst_n(rst_n),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]), .i_err(i_err[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ack(d_ack[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]), .busy(busy[1])
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int mkey(input int k, input logic [31:0] a);
        return k * 4096 + int'(a);
    endfunction

    // Transaction model: an access granted in an idle cycle acks WAIT_STATES+1 cycles later.
    bit          m_act    [NI];
    port_sel_t   m_port   [NI];
    port_sel_t   m_prio   [NI];
    logic [31:0] m_addr   [NI];
    logic        m_we     [NI];
    logic [31:0] m_wdata  [NI];
    int          m_left   [NI];
    logic [31:0] m_hold_i [NI];
    logic [31:0] m_hold_d [NI];
    logic [31:0] model_mem [int];

    always @(negedge clk1) begin
        for (int k = 0; k < NI; k++) begin
            logic        ack_now, err_now, e_iack, e_dack;
            logic [31:0] data_now, e_ird, e_drd;
            bit          known;
            if (!rst_n) begin
                m_act[k]    = 1'b0;
                m_prio[k]   = PORT_I;
                m_hold_i[k] = '0;
                m_hold_d[k] = '0;
            end
            ack_now  = m_act[k] && (m_left[k] == 0);
            err_now  = 1'b0;
            data_now = '0;
            known    = 1'b1;
            if (ack_now) begin
                err_now = (m_addr[k] >= 32'(DEPTH));
                if (!err_now && !m_we[k]) begin
                    if (model_mem.exists(mkey(k, m_addr[k]))) data_now = model_mem[mkey(k, m_addr[k])];
                    else known = 1'b0;
                end
            end
            e_iack = ack_now && (m_port[k] == PORT_I);
            e_dack = ack_now && (m_port[k] == PORT_D);
            e_ird  = e_iack ? data_now : m_hold_i[k];
            e_drd  = e_dack ? data_now : m_hold_d[k];
            check_output($sformatf("k%0d busy", k), 32'(busy[k]), 32'(m_act[k]));
            check_output($sformatf("k%0d i_ack", k), 32'(i_ack[k]), 32'(e_iack));
            check_output($sformatf("k%0d d_ack", k), 32'(d_ack[k]), 32'(e_dack));
            check_output($sformatf("k%0d i_err", k), 32'(i_err[k]), 32'(e_iack && err_now));
            check_output($sformatf("k%0d d_err", k), 32'(d_err[k]), 32'(e_dack && err_now));
            if (known) begin
                check_output($sformatf("k%0d i_rdata", k), i_rdata[k], e_ird);
                check_output($sformatf("k%0d d_rdata", k), d_rdata[k], e_drd);
            end
            if (rst_n) begin
                if (ack_now) begin
                    if (m_port[k] == PORT_D && m_we[k] && !err_now) model_mem[mkey(k, m_addr[k])] = m_wdata[k];
                    if (m_port[k] == PORT_I) m_hold_i[k] = data_now;
                    else m_hold_d[k] = data_now;
                    m_prio[k] = (m_port[k] == PORT_I) ? PORT_D : PORT_I;
                    m_act[k]  = 1'b0;
                end else if (m_act[k]) begin
                    m_left[k] = m_left[k] - 1;
                end else if (i_req[k] || d_req[k]) begin
                    if (i_req[k] && d_req[k]) m_port[k] = m_prio[k];
                    else m_port[k] = i_req[k] ? PORT_I : PORT_D;
                    m_addr[k]  = (m_port[k] == PORT_I) ? i_addr[k] : d_addr[k];
                    m_we[k]    = (m_port[k] == PORT_D) && d_we[k];
                    m_wdata[k] = d_wdata[k];
                    m_left[k]  = ws_of(k);
                    m_act[k]   = 1'b1;
                end
            end
        end
    end

    // Called 1ns after a rising edge; returns 1ns after the edge following the ack.
    task automatic apply_stimulus(input int k, input port_sel_t p, input logic we,
                                  input logic [31:0] addr, input logic [31:0] wdata, input bit drop,
                                  output int ack_cyc, output logic [31:0] rdata, output logic err);
        bit seen;
        seen    = 1'b0;
        ack_cyc = -1;
        rdata   = '0;
        err     = 1'b0;
        if (p == PORT_I) begin
            i_addr[k] = addr;
            i_req[k]  = 1'b1;
        end else begin
            d_we[k]    = we;
            d_addr[k]  = addr;
            d_wdata[k] = wdata;
            d_req[k]   = 1'b1;
        end
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk1);
            if (p == PORT_I && i_ack[k]) begin
                seen = 1'b1; ack_cyc = cyc; rdata = i_rdata[k]; err = i_err[k];
            end else if (p == PORT_D && d_ack[k]) begin
                seen = 1'b1; ack_cyc = cyc; rdata = d_rdata[k]; err = d_err[k];
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL ack timeout k%0d %s: got no ack, required one within 40 cycles", k, p.name());
        end
        @(posedge clk1);
        #1;
        if (drop) begin
            if (p == PORT_I) i_req[k] = 1'b0;
            else d_req[k] = 1'b0;
        end
    endtask

    initial begin
        int          c0, ca, cb, cc, cd;
        logic [31:0] rda, rdb, rdc, rdd;
        logic        era, erb, erc, erd;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_output("reset busy", 32'(busy[0]), 32'd0);
        check_output("reset i_ack", 32'(i_ack[0]), 32'd0);
        check_output("reset d_rdata", d_rdata[0], 32'd0);
        @(posedge clk1); #1 rst_n = 1'b1;
        @(posedge clk1); #1;

        // Instruction fetch of a preloaded word
        apply_stimulus(0, PORT_D, 1'b1, 32'd5, 32'h2801000A, 1'b1, ca, rda, era);
        c0 = cyc;
        apply_stimulus(0, PORT_I, 1'b0, 32'd5, 32'h0, 1'b1, ca, rda, era);
        check_output("t1 i latency", 32'(ca - c0), 32'd2);
        check_output("t1 i_rdata", rda, 32'h2801000A);
        check_output("t1 i_err", 32'(era), 32'd0);

        // Store then load of the same word
        apply_stimulus(0, PORT_D, 1'b1, 32'd100, 32'hDEADBEEF, 1'b1, ca, rda, era);
        check_output("t2 store d_rdata", rda, 32'h0);
        apply_stimulus(0, PORT_D, 1'b0, 32'd100, 32'h0, 1'b1, ca, rda, era);
        check_output("t2 load d_rdata", rda, 32'hDEADBEEF);

        // Simultaneous requests held back-to-back alternate I, D, I, D
        c0 = cyc;
        fork
            begin
                apply_stimulus(0, PORT_I, 1'b0, 32'd5, 32'h0, 1'b0, ca, rda, era);
                apply_stimulus(0, PORT_I, 1'b0, 32'd100, 32'h0, 1'b1, cb, rdb, erb);
            end
            begin
                apply_stimulus(0, PORT_D, 1'b0, 32'd100, 32'h0, 1'b0, cc, rdc, erc);
                apply_stimulus(0, PORT_D, 1'b0, 32'd5, 32'h0, 1'b1, cd, rdd, erd);
            end
        join
        check_output("t3 first I ack", 32'(ca - c0), 32'd2);
        check_output("t3 first D ack", 32'(cc - c0), 32'd5);
        check_output("t3 second I ack", 32'(cb - c0), 32'd8);
        check_output("t3 second D ack", 32'(cd - c0), 32'd11);
        check_output("t3 second D data", rdd, 32'h2801000A);

        // Out-of-range accesses
        apply_stimulus(0, PORT_D, 1'b1, 32'd0, 32'hA5A5A5A5, 1'b1, ca, rda, era);
        apply_stimulus(0, PORT_D, 1'b1, 32'd1024, 32'h12345678, 1'b1, ca, rda, era);
        check_output("t4 d_err", 32'(era), 32'd1);
        check_output("t4 err d_rdata", rda, 32'h0);
        apply_stimulus(0, PORT_D, 1'b0, 32'd0, 32'h0, 1'b1, ca, rda, era);
        check_output("t4 word 0 intact", rda, 32'hA5A5A5A5);
        apply_stimulus(0, PORT_I, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, ca, rda, era);
        check_output("t4 i_err", 32'(era), 32'd1);
        check_output("t4 err i_rdata", rda, 32'h0);

        // Reset while a store waits: no write, store re-granted after release
        apply_stimulus(0, PORT_D, 1'b1, 32'd200, 32'h11111111, 1'b1, ca, rda, era);
        d_we[0] = 1'b1; d_addr[0] = 32'd200; d_wdata[0] = 32'h22222222; d_req[0] = 1'b1;
        @(posedge clk1); #1;
        @(negedge clk1);
        check_output("t5 busy in wait", 32'(busy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        i_addr[0] = 32'd200;
        i_req[0]  = 1'b1;
        @(negedge clk1);
        check_output("t5 no d_ack in reset", 32'(d_ack[0]), 32'd0);
        @(posedge clk1); #1 rst_n = 1'b1;
        c0 = cyc;
        fork
            apply_stimulus(0, PORT_I, 1'b0, 32'd200, 32'h0, 1'b1, ca, rda, era);
            apply_stimulus(0, PORT_D, 1'b1, 32'd200, 32'h22222222, 1'b1, cb, rdb, erb);
        join
        check_output("t5 old value kept", rda, 32'h11111111);
        check_output("t5 store re-ack", 32'(cb - c0), 32'd5);
        apply_stimulus(0, PORT_D, 1'b0, 32'd200, 32'h0, 1'b1, ca, rda, era);
        check_output("t5 new value", rda, 32'h22222222);

        // Zero wait states: ack next cycle, back-to-back one per two cycles
        c0 = cyc;
        apply_stimulus(1, PORT_D, 1'b1, 32'd10, 32'h000000A0, 1'b0, ca, rda, era);
        check_output("t6 store latency", 32'(ca - c0), 32'd1);
        apply_stimulus(1, PORT_D, 1'b1, 32'd11, 32'h000000A1, 1'b0, ca, rda, era);
        apply_stimulus(1, PORT_D, 1'b1, 32'd12, 32'h000000A2, 1'b1, ca, rda, era);
        c0 = cyc;
        apply_stimulus(1, PORT_D, 1'b0, 32'd10, 32'h0, 1'b0, ca, rda, era);
        apply_stimulus(1, PORT_D, 1'b0, 32'd11, 32'h0, 1'b0, cb, rdb, erb);
        apply_stimulus(1, PORT_D, 1'b0, 32'd12, 32'h0, 1'b1, cc, rdc, erc);
        check_output("t6 load latency", 32'(ca - c0), 32'd1);
        check_output("t6 ack spacing 1", 32'(cb - ca), 32'd2);
        check_output("t6 ack spacing 2", 32'(cc - cb), 32'd2);
        check_output("t6 load data", rdc, 32'h000000A2);
        check_output("t6 load data 0", rda, 32'h000000A0);

        repeat (4) @(posedge clk1);
        @(negedge clk1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200us, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
